// File: rtl/integrator.sv
// Integrator: a wrapping signed accumulator with a registered valid/ready
// output flag. This is the integrator stage of a CIC filter. The running sum
// must wrap modulo 2^WordLengthBits. It must not saturate.
module integrator #(
    parameter int unsigned WordLengthBits = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WordLengthBits-1:0] in,
    input  logic                      in_valid,
    output logic [WordLengthBits-1:0] out,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WordLengthBits-1:0] acc_q, acc_d;
    logic                      out_valid_q, out_valid_d;

    // Next accumulator value: add the accepted sample, wrapping at full width.
    always_comb begin
        acc_d = acc_q;
        if (in_valid) begin
            acc_d = acc_q + in;
        end
    end

    // Next valid flag. A new sample takes priority over a consumer take, so
    // a simultaneous accept and take leaves a fresh result pending.
    always_comb begin
        out_valid_d = out_valid_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = acc_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_integrator.sv
// Directed testbench for integrator at a word length of 12 bits.
module tb_integrator;

    localparam int unsigned W = 12;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         in_valid;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;

    int total;
    int bad;

    integrator #(
        .WordLengthBits(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .in_valid (in_valid),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [W-1:0] exp_out, input logic exp_v);
        check({tag, "_out"}, out, exp_out);
        check({tag, "_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, exp_v});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq_a [6];
        logic [W-1:0] seq_w [6];
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Held reset ignores all inputs.
        in       = 12'hAAA;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_both("rst_hold", 12'h000, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check_both("rst_hold_ready", 12'h000, 1'b0);

        // Accumulate +3 three times, then -4 three times.
        rst       = 1'b0;
        in        = 12'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        seq_a = '{12'd3, 12'd6, 12'd9, 12'd5, 12'd1, 12'hFFD};
        for (int i = 0; i < 6; i++) begin
            if (i == 3) in = 12'hFFC;
            tick();
            check_both("acc_pm", seq_a[i], 1'b1);
        end

        // Wrap-around without saturation.
        do_reset();
        check_both("rst_before_wrap", 12'h000, 1'b0);
        in = 12'h300;
        seq_w = '{12'h300, 12'h600, 12'h900, 12'hC00, 12'hF00, 12'h200};
        for (int i = 0; i < 6; i++) begin
            tick();
            check_both("wrap", seq_w[i], 1'b1);
        end

        // Reset mid-operation discards the sum; first sample gives out=in.
        do_reset();
        check_both("mid_rst", 12'h000, 1'b0);
        in = 12'd7;
        tick();
        check_both("post_rst_first", 12'd7, 1'b1);

        // in_valid=0 holds regardless of in.
        do_reset();
        in        = 12'hAAA;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_both("idle_hold", 12'h000, 1'b0);
        end
        in       = 12'h000;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_both("zero_stream", 12'h000, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_both("drain", 12'h000, 1'b0);
        tick();
        check_both("drain_stay", 12'h000, 1'b0);

        // Single pulse: valid persists until taken; out ignores in and out_ready.
        do_reset();
        out_ready = 1'b0;
        in        = 12'd5;
        in_valid  = 1'b1;
        tick();
        check_both("pulse", 12'd5, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 120; i++) begin
            in = W'($urandom);
            tick();
            check_both("pulse_hold", 12'd5, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        check_both("take", 12'd5, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_both("taken_stay", 12'd5, 1'b0);
        end

        // Unconsumed result overwritten by a new sample (no stall).
        in       = 12'd10;
        in_valid = 1'b1;
        tick();
        check_both("overwrite1", 12'd15, 1'b1);
        tick();
        check_both("overwrite2", 12'd25, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/integrator.md
INTEGRATOR -- requirements
Module: integrator

Interface
REQ-001 Parameter WordLengthBits, default 16: width in bits of input, accumulator and output; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled on rising clk.
REQ-004 in  input  WordLengthBits  signed two's-complement sample to accumulate.
REQ-005 in_valid  input  1  qualifies in; sample accepted on every rising edge where in_valid=1 (no in_ready, never back-pressured).
REQ-006 out  output  WordLengthBits  signed running sum; driven directly from the accumulator register.
REQ-007 out_valid  output  1  registered flag: out holds a result not yet taken by the consumer.
REQ-008 out_ready  input  1  consumer acknowledge; out is taken on a rising edge where out_valid=1 and out_ready=1.

Function
REQ-009 Accumulator acc (WordLengthBits, signed) SHALL update acc <= acc + in on each rising edge with in_valid=1 and rst=0; otherwise hold.
REQ-010 Addition SHALL wrap modulo 2^WordLengthBits: no saturation, no overflow flag, no width growth (required for CIC operation).
REQ-011 out SHALL equal acc at all times; latency in -> out is exactly one clock, no combinational path from in to out.
REQ-012 out_valid next-state, priority order: rst -> 0; else in_valid=1 -> 1; else out_ready=1 -> 0; else hold.
REQ-013 in_valid=1 together with out_ready=1 SHALL leave out_valid=1 (new result replaces the one taken).
REQ-014 out_ready SHALL NOT affect acc or out; unconsumed results are overwritten by new accepted samples (no stall, no FIFO).
REQ-015 When in_valid=0, out and acc SHALL hold regardless of in value.
REQ-016 out_valid SHALL stay 1 indefinitely while in_valid=0 and out_ready=0.

Reset
REQ-017 With rst=1 at a rising edge, acc/out SHALL become 0 and out_valid 0.
REQ-018 While rst stays 1, out=0 and out_valid=0 SHALL hold regardless of in, in_valid, out_ready.
REQ-019 Reset mid-operation SHALL discard the running sum; first sample after release yields out=in.

Structure
REQ-020 No shared package needed; WordLengthBits is the only parameter.
REQ-021 Single flat module, no sub-modules; two registers (acc, out_valid).

Verification
REQ-022 Hold rst=1, in=0xAAA, in_valid=1, out_ready=0 for 1000 cycles -> out=0, out_valid=0 every cycle.
REQ-023 W=12, in=3, in_valid=1, out_ready=1 -> out 0,3,6,9; then in=-4 -> 5,1,-3 on successive cycles.
REQ-024 W=12, in=0x300 continuously -> out 0x300,0x600,0x900,0xC00,0xF00,0x200 (wrap, no saturation).
REQ-025 in=0xAAA, in_valid=0, out_ready=1 for 1000 cycles -> out=0, out_valid=0; then in=0, in_valid=1 -> out_valid=1, out=0 for 1000 cycles; then in_valid=0 -> out_valid=0 one cycle later, out stays 0.
REQ-026 out_ready=0, one-cycle in_valid pulse -> out_valid=1 for 100+ cycles; one-cycle out_ready pulse -> out_valid=0 next cycle and stays 0.
REQ-027 in=0, in_valid=1 for 1000 cycles after reset -> out=0 throughout.
